systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Downstream neighbour of the matrix input datapath.
- Takes the eight pre-skewed operand vectors (four A rows, four B columns; 56 bits each, zero-padded into a diagonal skew) once the load is complete.
- Streams them one byte per cycle into the left and top edges of the 4x4 systolic MAC array.
- Sequences accumulator clear, feed, drain and a result handshake toward the output stage.

Parameters:
- DATA_W, 8, operand byte width.
- N, 4, array dimension; skewed vector length is SKEW_LEN = 2*N-1 = 7 elements (56 bits).
- DRAIN_CYCLES, 4, cycles mac_en stays high after the last feed byte. Default is N: N-1 hops to the far PE plus 1 accumulate.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  load-complete pulse from the input datapath; sampled only in IDLE.
- flush  in  1  synchronous abort, returns to IDLE.
- a_row0..a_row3  in  56 each  skewed A rows; byte [55:48] is emitted first.
- b_col0..b_col3  in  56 each  skewed B columns; same byte order.
- result_ack  in  1  output stage has taken the result.
- a_feed  out  32  left-edge bytes; row i on bits [8i+7:8i].
- b_feed  out  32  top-edge bytes; column j on bits [8j+7:8j].
- feed_valid  out  1  a_feed/b_feed carry stream data this cycle.
- pe_clear  out  1  one-cycle accumulator clear to all PEs.
- mac_en  out  1  PEs shift operands and accumulate.
- busy  out  1  high in every state except IDLE.
- done  out  1  result available; held until acknowledged.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; all shift registers and counters clear to 0.
  - a_feed, b_feed = 0; feed_valid, pe_clear, mac_en, busy, done = 0.
- Five states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - All outputs are 0.
  - start=1 captures all eight input vectors into internal 56-bit shift registers and moves to CLEAR.
- CLEAR (1 cycle):
  - pe_clear=1, busy=1; moves to FEED with the element counter set to 0.
- FEED (exactly SKEW_LEN = 7 cycles):
  - feed_valid=1, mac_en=1.
  - Each byte lane of a_feed/b_feed drives bits [55:48] of its shift register.
  - Every register shifts left by DATA_W with zero fill each cycle.
  - After counter value 6, moves to DRAIN with the counter reset.
- DRAIN (DRAIN_CYCLES cycles):
  - mac_en=1, feed_valid=0, a_feed/b_feed forced to 0.
  - After the last drain cycle, moves to DONE.
- DONE:
  - done=1, busy=1, mac_en=0; holds until result_ack=1, then returns to IDLE.
- Latency: start accepted at cycle T → pe_clear at T+1 → feed T+2..T+8 → drain T+9..T+12 → done first high at T+13.
- The skew comes entirely from the inputs; the feeder adds no per-row delay.
  - Row 0 data appears at feed cycles 0-3.
  - Row 3 data appears at feed cycles 3-6.
- start outside IDLE: ignored. Input vectors are sampled only at capture; later changes have no effect.
- flush=1 in any state:
  - Next state IDLE; shift registers and counters cleared; all outputs 0 next cycle.
  - flush wins over a simultaneous start or result_ack.
- result_ack outside DONE: ignored.
- result_ack and start in the same cycle while in DONE: return to IDLE only. That start is dropped; a new start must arrive while in IDLE.
- Asynchronous reset mid-FEED or mid-DRAIN: immediate return to reset values. No partial done is ever produced.
- Counters are sized for max(SKEW_LEN, DRAIN_CYCLES). No wrap is possible within a state.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset low 3 cycles, release, keep start=0 for 10 cycles.
  - Required: all outputs 0 and busy=0 throughout.
- Nominal run:
  - Stimulus: a_row0={32'h01020304,24'h0}, a_row1={8'h0,32'h05060708,16'h0}, a_row2={16'h0,32'h090A0B0C,8'h0}, a_row3={24'h0,32'h0D0E0F10}; the same values on b_col0..b_col3; pulse start at T.
  - Required: pe_clear at T+1.
  - Required a_feed at T+2..T+8: 32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704, 32'h0E0B0800, 32'h0F0C0000, 32'h10000000.
  - Required: mac_en high T+2..T+12; done at T+13.
- Done hold and acknowledge:
  - Stimulus: after the nominal run, keep result_ack=0 for 5 cycles, then pulse result_ack.
  - Required: done stays 1 for those 5 cycles; busy=0 and done=0 on the cycle after the ack.
- start while busy:
  - Stimulus: pulse start again at T+5 with different vectors.
  - Required: the feed stream is unchanged from the nominal run; done still at T+13.
- Flush mid-feed:
  - Stimulus: assert flush at T+4.
  - Required: from T+5, all outputs 0 and state IDLE; a fresh start at T+7 gives a complete nominal sequence with done at T+20.
- Async reset mid-drain:
  - Stimulus: drive reset low at T+10, between clock edges.
  - Required: mac_en, busy and the feed outputs go 0 immediately, and done never asserts.

Source files
------------

// File: rtl/systolic_feeder.sv
// Streams four pre-skewed A rows and four B columns, one byte per cycle, into the edges of an
// NxN systolic MAC array, and sequences clear, feed, drain and the result handshake.
module systolic_feeder #(
    parameter int DATA_W       = 8,
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = N
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        flush,
    input  logic [(2*N-1)*DATA_W-1:0]   a_row0,
    input  logic [(2*N-1)*DATA_W-1:0]   a_row1,
    input  logic [(2*N-1)*DATA_W-1:0]   a_row2,
    input  logic [(2*N-1)*DATA_W-1:0]   a_row3,
    input  logic [(2*N-1)*DATA_W-1:0]   b_col0,
    input  logic [(2*N-1)*DATA_W-1:0]   b_col1,
    input  logic [(2*N-1)*DATA_W-1:0]   b_col2,
    input  logic [(2*N-1)*DATA_W-1:0]   b_col3,
    input  logic                        result_ack,
    output logic [N*DATA_W-1:0]         a_feed,
    output logic [N*DATA_W-1:0]         b_feed,
    output logic                        feed_valid,
    output logic                        pe_clear,
    output logic                        mac_en,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  state_dbg
);

    localparam int SKEW_LEN = 2*N - 1;
    localparam int VEC_W    = SKEW_LEN * DATA_W;
    localparam int CNT_MAX  = ((SKEW_LEN > DRAIN_CYCLES) ? SKEW_LEN : DRAIN_CYCLES) - 1;
    localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(SKEW_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               load, shift, clr;
    logic [VEC_W-1:0]   a_sr [N];
    logic [VEC_W-1:0]   b_sr [N];

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Result handshake: done is the valid, result_ack the ready; the result is taken on the
    // first cycle both are high, and done is held until then.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load       = 1'b0;
        shift      = 1'b0;
        clr        = 1'b0;
        feed_valid = 1'b0;
        pe_clear   = 1'b0;
        mac_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        a_feed     = '0;
        b_feed     = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    load    = 1'b1;
                end
            end
            CLEAR: begin
                pe_clear = 1'b1;
                busy     = 1'b1;
                state_n  = FEED;
                cnt_n    = '0;
            end
            FEED: begin
                feed_valid = 1'b1;
                mac_en     = 1'b1;
                busy       = 1'b1;
                shift      = 1'b1;
                for (int i = 0; i < N; i++) begin
                    a_feed[i*DATA_W +: DATA_W] = a_sr[i][VEC_W-1 -: DATA_W];
                    b_feed[i*DATA_W +: DATA_W] = b_sr[i][VEC_W-1 -: DATA_W];
                end
                if (cnt == LAST_FEED) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                mac_en = 1'b1;
                busy   = 1'b1;
                if (cnt == LAST_DRAIN) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
                // A start arriving together with the ack is deliberately dropped.
                if (result_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides every transition; outputs of this cycle are left as decoded.
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            clr     = 1'b1;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    // Skew is already in the vectors, so every lane just shifts out MSB-first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else if (load) begin
            a_sr[0] <= a_row0;
            a_sr[1] <= a_row1;
            a_sr[2] <= a_row2;
            a_sr[3] <= a_row3;
            b_sr[0] <= b_col0;
            b_sr[1] <= b_col1;
            b_sr[2] <= b_col2;
            b_sr[3] <= b_col3;
        end else if (shift) begin
            for (int i = 0; i < N; i++) begin
                a_sr[i] <= a_sr[i] << DATA_W;
                b_sr[i] <= b_sr[i] << DATA_W;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed scenarios with literal expectations plus randomized runs,
// all outputs compared every cycle against a cycle-offset model of a feed transaction.
module tb_systolic_feeder;

    localparam int DATA_W   = 8;
    localparam int N        = 4;
    localparam int DRAIN    = N;
    localparam int SKEW_LEN = 2*N - 1;
    localparam int VEC_W    = SKEW_LEN * DATA_W;
    localparam int FEED_LO  = 2;
    localparam int FEED_HI  = 1 + SKEW_LEN;
    localparam int DONE_K   = 2 + SKEW_LEN + DRAIN;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, flush = 1'b0, result_ack = 1'b0;
    logic [VEC_W-1:0] a_vec [N];
    logic [VEC_W-1:0] b_vec [N];
    logic [N*DATA_W-1:0] a_feed, b_feed;
    logic feed_valid, pe_clear, mac_en, busy, done;
    logic [2:0] state_dbg;

    systolic_feeder #(.DATA_W(DATA_W), .N(N), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .a_row0(a_vec[0]), .a_row1(a_vec[1]), .a_row2(a_vec[2]), .a_row3(a_vec[3]),
        .b_col0(b_vec[0]), .b_col1(b_vec[1]), .b_col2(b_vec[2]), .b_col3(b_vec[3]),
        .result_ack(result_ack), .a_feed(a_feed), .b_feed(b_feed),
        .feed_valid(feed_valid), .pe_clear(pe_clear), .mac_en(mac_en),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [N*DATA_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a transaction is "k cycles after the accepting edge"; outputs follow from k.
    bit               m_busy = 1'b0;
    int               m_k    = 0;
    logic [VEC_W-1:0] m_a [N];
    logic [VEC_W-1:0] m_b [N];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (flush) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_k    = 1;
                for (int i = 0; i < N; i++) begin
                    m_a[i] = a_vec[i];
                    m_b[i] = b_vec[i];
                end
            end
        end else if (m_k >= DONE_K) begin
            if (result_ack) begin
                m_busy = 1'b0;
                m_k    = 0;
            end
        end else begin
            m_k++;
        end
    end

    logic [N*DATA_W-1:0] e_a, e_b;
    int                  e_idx;
    bit                  e_feed;

    // compare process: every output, every cycle, on the falling edge
    always @(negedge clk) begin
        e_a    = '0;
        e_b    = '0;
        e_feed = m_busy && (m_k >= FEED_LO) && (m_k <= FEED_HI);
        e_idx  = m_k - FEED_LO;
        if (e_feed) begin
            for (int i = 0; i < N; i++) begin
                e_a[i*DATA_W +: DATA_W] = m_a[i][VEC_W-1 - e_idx*DATA_W -: DATA_W];
                e_b[i*DATA_W +: DATA_W] = m_b[i][VEC_W-1 - e_idx*DATA_W -: DATA_W];
            end
        end
        check("cyc_a_feed", 64'(a_feed), 64'(e_a));
        check("cyc_b_feed", 64'(b_feed), 64'(e_b));
        check("cyc_feed_valid", 64'(feed_valid), 64'(e_feed));
        check("cyc_pe_clear", 64'(pe_clear), 64'(m_busy && m_k == 1));
        check("cyc_mac_en", 64'(mac_en), 64'(m_busy && m_k >= FEED_LO && m_k < DONE_K));
        check("cyc_busy", 64'(busy), 64'(m_busy));
        check("cyc_done", 64'(done), 64'(m_busy && m_k >= DONE_K));
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_nominal();
        a_vec[0] = {32'h01020304, 24'h0};
        a_vec[1] = {8'h0, 32'h05060708, 16'h0};
        a_vec[2] = {16'h0, 32'h090A0B0C, 8'h0};
        a_vec[3] = {24'h0, 32'h0D0E0F10};
        for (int i = 0; i < N; i++) b_vec[i] = a_vec[i];
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            a_vec[i] = VEC_W'({$urandom(), $urandom()});
            b_vec[i] = VEC_W'({$urandom(), $urandom()});
        end
    endtask

    // Starts in cycle T, returns positioned in cycle T+13 (done expected).
    task automatic run_nominal(input int busy_start_c);
        logic [N*DATA_W-1:0] exp_v;
        set_nominal();
        exp_q = {32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
                 32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nom_pe_clear_t1", 64'(pe_clear), 64'd1);
        check("nom_busy_t1", 64'(busy), 64'd1);
        for (int c = 2; c <= DONE_K; c++) begin
            tick();
            if (c <= FEED_HI) begin
                exp_v = exp_q.pop_front();
                check("nom_a_feed", 64'(a_feed), 64'(exp_v));
                check("nom_b_feed", 64'(b_feed), 64'(exp_v));
            end
            check("nom_mac_en", 64'(mac_en), 64'(c < DONE_K));
            check("nom_done", 64'(done), 64'(c == DONE_K));
            start = (c == busy_start_c);
            if (c == busy_start_c) set_random();
        end
        start = 1'b0;
    endtask

    task automatic ack_done();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_done", 64'(done), 64'd1);
        end
        result_ack = 1'b1;
        start      = 1'b1;
        tick();
        result_ack = 1'b0;
        start      = 1'b0;
        check("ack_busy", 64'(busy), 64'd0);
        check("ack_done", 64'(done), 64'd0);
        tick();
        check("ack_start_dropped", 64'(pe_clear), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_vec[i] = '0;
            b_vec[i] = '0;
        end

        // reset then idle
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_feed", 64'({a_feed, b_feed}), 64'd0);
        end

        // nominal run, done hold, ack with simultaneous start
        run_nominal(0);
        ack_done();

        // start while busy is ignored
        tick();
        run_nominal(5);
        ack_done();

        // flush mid-feed, then a fresh start at T+7
        set_nominal();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_mac_en", 64'(mac_en), 64'd0);
        check("flush_feed", 64'({a_feed, b_feed}), 64'd0);
        repeat (2) tick();
        run_nominal(0);
        ack_done();

        // asynchronous reset mid-drain
        set_nominal();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #1 reset = 1'b0;
        #1;
        check("arst_mac_en", 64'(mac_en), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_feed", 64'({a_feed, b_feed, feed_valid}), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("arst_no_done", 64'(done), 64'd0);
        end

        // randomized runs with noise on start, flush and result_ack
        for (int r = 0; r < 30; r++) begin
            set_random();
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (($urandom_range(0, 3) == 0)) set_random();
                start      = ($urandom_range(0, 4) == 0);
                flush      = ($urandom_range(0, 39) == 0);
                result_ack = ($urandom_range(0, 5) == 0);
                tick();
            end
            start      = 1'b0;
            flush      = 1'b0;
            result_ack = 1'b1;
            repeat (DONE_K + 2) tick();
            result_ack = 1'b0;
            check("rand_returns_idle", 64'(busy), 64'd0);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
